// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature sample controller.
//   mode_t    : display selection (LIVE, MIN, MAX, AVG)
//   state_t   : sample acquisition FSM states
//   TEMP_W    : sensor word width (two's complement, 4 fractional bits)
//   SUM_W     : running-sum width of the averaging window
//   AVG_DEPTH : number of samples in the averaging window
package temp_pkg;

   localparam int TEMP_W    = 13;
   localparam int SUM_W     = 16;
   localparam int AVG_DEPTH = 8;
   localparam int PTR_W     = $clog2(AVG_DEPTH);
   localparam int CNT_W     = $clog2(AVG_DEPTH + 1);

   typedef enum logic [1:0] {
      MODE_LIVE = 2'd0,
      MODE_MIN  = 2'd1,
      MODE_MAX  = 2'd2,
      MODE_AVG  = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_CAPTURE,
      S_UPDATE,
      S_FAIL
   } state_t;

   function automatic mode_t next_mode(input mode_t m);
      mode_t r;
      unique case (m)
         MODE_LIVE: r = MODE_MIN;
         MODE_MIN:  r = MODE_MAX;
         MODE_MAX:  r = MODE_AVG;
         default:   r = MODE_LIVE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/temp_sample_ctl_if.sv
// Signal bundle between the sensor/button side and temp_sample_ctl.
//   temp, tmp_rdy, tmp_err : sensor result, valid level, bus-error level
//   mode_btn, clr          : debounced mode button level, statistics clear
//   sel_temp, mode         : selected value for the display path, current mode
//   stale, filled          : last attempt failed, averaging window full
// master drives the inputs of the controller; slave is the controller.
interface temp_sample_ctl_if;
   import temp_pkg::*;

   logic [TEMP_W-1:0] temp;
   logic              tmp_rdy;
   logic              tmp_err;
   logic              mode_btn;
   logic              clr;
   logic [TEMP_W-1:0] sel_temp;
   logic [1:0]        mode;
   logic              stale;
   logic              filled;

   modport master (
      output temp, tmp_rdy, tmp_err, mode_btn, clr,
      input  sel_temp, mode, stale, filled
   );

   modport slave (
      input  temp, tmp_rdy, tmp_err, mode_btn, clr,
      output sel_temp, mode, stale, filled
   );
endinterface

// File: rtl/temp_avg_buf.sv
// 8-entry ring buffer with running sum and fill tracking.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : empty the buffer (wins over wr_i)
//   wr_i      : write din_i as the newest sample
//   din_i     : sample to write
//   sum_o     : signed sum of the samples currently in the window
//   count_o   : samples held, saturating at AVG_DEPTH
//   filled_o  : window has been full since the last reset/clear
module temp_avg_buf
   import temp_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic                    wr_i,
   input  logic [TEMP_W-1:0]       din_i,
   output logic signed [SUM_W-1:0] sum_o,
   output logic [CNT_W-1:0]        count_o,
   output logic                    filled_o
);

   logic [TEMP_W-1:0]       mem_q [AVG_DEPTH];
   logic [PTR_W-1:0]        wp_q;
   logic signed [SUM_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    filled_q, filled_d;
   logic [TEMP_W-1:0]       oldest;

   always_comb begin
      // Until the window is full the slot being overwritten holds no sample.
      oldest   = filled_q ? mem_q[wp_q] : '0;
      sum_d    = sum_q + {{(SUM_W-TEMP_W){din_i[TEMP_W-1]}}, din_i}
                       - {{(SUM_W-TEMP_W){oldest[TEMP_W-1]}}, oldest};
      count_d  = (count_q == CNT_W'(AVG_DEPTH)) ? count_q : count_q + 1'b1;
      filled_d = filled_q | (count_q == CNT_W'(AVG_DEPTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < AVG_DEPTH; i++) mem_q[i] <= '0;
         wp_q     <= '0;
         sum_q    <= '0;
         count_q  <= '0;
         filled_q <= 1'b0;
      end else if (clr_i) begin
         for (int unsigned i = 0; i < AVG_DEPTH; i++) mem_q[i] <= '0;
         wp_q     <= '0;
         sum_q    <= '0;
         count_q  <= '0;
         filled_q <= 1'b0;
      end else if (wr_i) begin
         mem_q[wp_q] <= din_i;
         wp_q        <= wp_q + 1'b1;
         sum_q       <= sum_d;
         count_q     <= count_d;
         filled_q    <= filled_d;
      end
   end

   assign sum_o    = sum_q;
   assign count_o  = count_q;
   assign filled_o = filled_q;

endmodule

// File: rtl/temp_sample_ctl.sv
// Periodic temperature sampler with min/max/average statistics and a
// button-selected, registered display value.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of temp_sample_ctl_if
//              in : temp, tmp_rdy, tmp_err, mode_btn, clr
//              out: sel_temp, mode, stale, filled
// Parameters: SAMPLE_DIV cycles between sample requests, RDY_TIMEOUT cycles
// allowed for the sensor to answer a request.
module temp_sample_ctl
   import temp_pkg::*;
#(
   parameter int SAMPLE_DIV  = 100_000_000,
   parameter int RDY_TIMEOUT = 1_000_000
) (
   input logic              clk,
   input logic              rst,
   temp_sample_ctl_if.slave bus
);

   localparam int TMR_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int WAIT_W = $clog2(RDY_TIMEOUT) + 1;
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SAMPLE_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RDY_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               tick, cap_en, upd_en, fail_en, upd_ok;

   logic [TEMP_W-1:0]  sample_q, sample_d;
   logic [TEMP_W-1:0]  latest_q, latest_d;
   logic [TEMP_W-1:0]  min_q, min_d;
   logic [TEMP_W-1:0]  max_q, max_d;
   logic [TEMP_W-1:0]  sel_q, sel_d;
   logic               stale_q, stale_d;
   logic               btn_q, btn_d;
   mode_t              mode_q, mode_d;

   logic signed [SUM_W-1:0] avg_sum, avg_shift;
   logic [CNT_W-1:0]        avg_count;
   logic                    avg_filled;
   logic [TEMP_W-1:0]       avg_val;

   // Free-running sample timer; tick is the wrap cycle.
   assign tick  = (tmr_q == TMR_LAST);
   assign tmr_d = tick ? '0 : tmr_q + 1'b1;

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      cap_en  = 1'b0;
      upd_en  = 1'b0;
      fail_en = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (tick) state_d = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
            if (bus.tmp_err)             state_d = S_FAIL;
            else if (bus.tmp_rdy)        state_d = S_CAPTURE;
            else if (wait_q == WAIT_LAST) state_d = S_FAIL;
            else                         wait_d  = wait_q + 1'b1;
         end
         S_CAPTURE: begin
            cap_en  = 1'b1;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            upd_en  = 1'b1;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            fail_en = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A clear landing on the update cycle discards the sample entirely.
   assign upd_ok = upd_en & ~bus.clr;

   temp_avg_buf u_avg (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (bus.clr),
      .wr_i     (upd_ok),
      .din_i    (sample_q),
      .sum_o    (avg_sum),
      .count_o  (avg_count),
      .filled_o (avg_filled)
   );

   always_comb begin
      sample_d = cap_en ? bus.temp : sample_q;
      latest_d = upd_ok ? sample_q : latest_q;

      min_d = min_q;
      max_d = max_q;
      if (bus.clr) begin
         min_d = '0;
         max_d = '0;
      end else if (upd_ok) begin
         if (avg_count == '0) begin
            min_d = sample_q;
            max_d = sample_q;
         end else begin
            if ($signed(sample_q) < $signed(min_q)) min_d = sample_q;
            if ($signed(sample_q) > $signed(max_q)) max_d = sample_q;
         end
      end

      stale_d = stale_q;
      if (fail_en)     stale_d = 1'b1;
      else if (upd_ok) stale_d = 1'b0;

      btn_d  = bus.mode_btn;
      mode_d = mode_q;
      if (bus.mode_btn && !btn_q) mode_d = next_mode(mode_q);

      avg_shift = avg_sum >>> PTR_W;
      avg_val   = avg_filled ? avg_shift[TEMP_W-1:0] : latest_q;

      unique case (mode_q)
         MODE_LIVE: sel_d = latest_q;
         MODE_MIN:  sel_d = min_q;
         MODE_MAX:  sel_d = max_q;
         default:   sel_d = avg_val;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         wait_q   <= '0;
         sample_q <= '0;
         latest_q <= '0;
         min_q    <= '0;
         max_q    <= '0;
         sel_q    <= '0;
         stale_q  <= 1'b0;
         btn_q    <= 1'b0;
         mode_q   <= MODE_LIVE;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         wait_q   <= wait_d;
         sample_q <= sample_d;
         latest_q <= latest_d;
         min_q    <= min_d;
         max_q    <= max_d;
         sel_q    <= sel_d;
         stale_q  <= stale_d;
         btn_q    <= btn_d;
         mode_q   <= mode_d;
      end
   end

   assign bus.sel_temp = sel_q;
   assign bus.mode     = mode_q;
   assign bus.stale    = stale_q;
   assign bus.filled   = avg_filled;

endmodule

// File: doc/temp_sample_ctl.md
TEMP_SAMPLE_CTL -- requirements
Module: temp_sample_ctl

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 100_000_000: clk cycles between sample requests.
REQ-002 The block SHALL have parameter RDY_TIMEOUT, default 1_000_000: max cycles to wait for tmp_rdy after a request.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port temp  input  13  sensor result, two's complement, 4 fractional bits.
REQ-006 The block SHALL have port tmp_rdy  input  1  sensor result valid (level).
REQ-007 The block SHALL have port tmp_err  input  1  sensor bus error (level).
REQ-008 The block SHALL have port mode_btn  input  1  synchronous level from debounced button; each rising edge advances the mode.
REQ-009 The block SHALL have port clr  input  1  synchronous clear of statistics.
REQ-010 The block SHALL have port sel_temp  output  13  value for the shared conversion/display datapath.
REQ-011 The block SHALL have port mode  output  2  0 LIVE, 1 MIN, 2 MAX, 3 AVG.
REQ-012 The block SHALL have port stale  output  1  last sample attempt failed.
REQ-013 The block SHALL have port filled  output  1  8-sample average window full.

Function
REQ-014 Sample timer SHALL count 0..SAMPLE_DIV-1, wrap to 0 and pulse tick for one cycle at wrap.
REQ-015 FSM states SHALL be IDLE, WAIT_RDY, CAPTURE, UPDATE, FAIL.
REQ-016 IDLE -> WAIT_RDY on tick; ticks arriving outside IDLE SHALL be dropped, not queued.
REQ-017 WAIT_RDY -> CAPTURE when tmp_rdy=1 and tmp_err=0; -> FAIL if tmp_err=1 or wait counter reaches RDY_TIMEOUT; tmp_err takes priority over tmp_rdy in the same cycle.
REQ-018 CAPTURE SHALL register temp; UPDATE SHALL write it to the 8-entry ring buffer, update sum, min, max and count; both SHALL last exactly one cycle, then -> IDLE.
REQ-019 FAIL SHALL set stale=1, discard the sample and go -> IDLE after one cycle; the next successful UPDATE SHALL clear stale.
REQ-020 Running sum SHALL be 16-bit signed: sum_next = sum + new - oldest, where oldest is 0 until the buffer is full.
REQ-021 filled SHALL assert on the UPDATE that writes the 8th sample and stay high until reset or clr.
REQ-022 The average SHALL be sum >>> 3 (arithmetic) when filled=1, otherwise the latest sample.
REQ-023 Min and max SHALL be signed comparisons; the first sample after reset or clr SHALL load both.
REQ-024 A mode_btn rising edge SHALL advance mode LIVE->MIN->MAX->AVG->LIVE, updating mode one cycle after the edge is detected; a held level SHALL advance only once.
REQ-025 sel_temp SHALL be a registered mux of latest, min, max or average per mode, valid one cycle after the source or mode changes.
REQ-026 Before the first successful sample, sel_temp SHALL be 0 in every mode.
REQ-027 clr SHALL empty the buffer and zero sum, count, filled, min and max in one cycle; it SHALL NOT affect mode, stale, the timer or the FSM; if clr coincides with UPDATE, clr wins and the sample is discarded.

Reset
REQ-028 On rst: FSM=IDLE, timer=0, wait counter=0, buffer, sum, count, min and max=0, mode=LIVE, sel_temp=0, stale=0, filled=0, button edge register=0.
REQ-029 rst asserted mid-WAIT_RDY or mid-UPDATE SHALL abort with no partial statistics update.

Structure
REQ-030 Package temp_pkg SHALL hold mode_t, state_t, TEMP_W=13, SUM_W=16 and AVG_DEPTH=8.
REQ-031 The ring buffer, sum and fill logic SHALL be one sub-module, temp_avg_buf; the FSM, timer, min/max, mode and mux SHALL stay in temp_sample_ctl.

Verification (SAMPLE_DIV=10, RDY_TIMEOUT=5)
REQ-032 tmp_rdy=1, temp=0x190 (25.0C), 8 ticks -> filled=1; mode AVG gives sel_temp=0x190.
REQ-033 Samples 0x190 then 0x1FF0 (-1.0C) -> MIN mode 0x1FF0, MAX mode 0x190.
REQ-034 tmp_rdy held 0 for the whole tick -> FAIL after 5 cycles, stale=1, sel_temp unchanged; next good sample -> stale=0.
REQ-035 tmp_err=1 and tmp_rdy=1 in the same cycle -> FAIL taken, no statistics change.
REQ-036 Four mode_btn pulses -> mode 1,2,3,0; mode_btn held high 50 cycles -> exactly one advance.
REQ-037 clr asserted in the UPDATE cycle -> count=0, filled=0, sample discarded; rst asserted mid-WAIT_RDY -> all outputs at reset values.
